load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters: none; address and data widths are fixed at 16 bits.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  pipeline presents an access request.
REQ-005 req_ready  output  1  unit can accept a request; high only in IDLE.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_byte  input  1  1 = byte access, 0 = halfword access.
REQ-008 req_signed  input  1  byte loads only: 1 = sign-extend, 0 = zero-extend.
REQ-009 req_addr  input  16  byte address; any alignment is legal.
REQ-010 req_wdata  input  16  store data; byte stores use bits [7:0] only.
REQ-011 rsp_valid  output  1  access complete; rsp_rdata is valid.
REQ-012 rsp_ready  input  1  pipeline accepts the response.
REQ-013 rsp_rdata  output  16  load result; 0x0000 for stores.
REQ-014 mem_addr  output  16  byte address to the memory.
REQ-015 mem_wdata  output  16  write data to the memory; bits [7:0] go to addr, bits [15:8] to addr+1.
REQ-016 mem_we  output  1  memory write enable; the memory writes both bytes on the clock edge.
REQ-017 mem_rdata  input  16  combinational read data from the memory: {mem[addr+1], mem[addr]}.

Function
REQ-018 FSM states: IDLE, ACCESS, RMW_WR, RESP.
REQ-019 Handshake: a request is accepted on a clock edge where state=IDLE and req_valid=1.
  - On acceptance, latch addr, we, byte, signed, wdata.
  - Next state is ACCESS.
REQ-020 mem_addr shall equal the latched address in ACCESS and RMW_WR, and hold its last value elsewhere.
REQ-021 ACCESS, load: capture mem_rdata at the end of the cycle, with mem_we=0; next state RESP.
REQ-022 Load result formatting:
  - Halfword load returns mem_rdata unchanged.
  - Byte load returns mem_rdata[7:0], zero- or sign-extended to 16 bits per the latched signed bit.
REQ-023 ACCESS, halfword store: mem_we=1 and mem_wdata=latched wdata for exactly one cycle; next state RESP.
REQ-024 ACCESS, byte store: read with mem_we=0 and capture mem_rdata[15:8]; next state RMW_WR.
REQ-025 RMW_WR: mem_we=1 and mem_wdata={captured high byte, wdata[7:0]} for exactly one cycle; next state RESP.
  - This preserves the byte at addr+1.
REQ-026 mem_we shall be 0 in every state and cycle other than those in REQ-023 and REQ-025.
REQ-027 RESP: rsp_valid=1, and rsp_rdata shall be held stable until rsp_ready=1.
  - A cycle with rsp_ready=1 completes the response; next state IDLE.
REQ-028 Latency from the acceptance edge to rsp_valid:
  - Load: 2 cycles.
  - Halfword store: 2 cycles.
  - Byte store: 3 cycles.
  - Add any rsp_ready backpressure cycles on top.
REQ-029 At most one request is outstanding; req_ready=0 outside IDLE.
  - A request cannot be accepted in the same cycle a response completes.
REQ-030 Address wrap: the unit passes addr unmodified; it performs no addr+1 arithmetic.
  - A halfword at 0xFFFF uses 0xFFFF (low byte) and 0x0000 (high byte), per the memory's 16-bit wrap.
REQ-031 req_signed is ignored for halfword loads and for stores.

Reset
REQ-032 While rst_n=0 at a clock edge:
  - state becomes IDLE.
  - rsp_valid=0, rsp_rdata=0x0000.
  - mem_we=0, mem_addr=0x0000, mem_wdata=0x0000.
  - All latched request fields become 0.
REQ-033 Reset mid-operation (ACCESS, RMW_WR or RESP) shall abandon the access.
  - No mem_we pulse is issued on or after the reset edge.
  - No response is issued.
REQ-034 A request presented while rst_n=0 is not accepted.
REQ-035 req_ready=1 in the first cycle after rst_n returns high.

Structure
REQ-036 Shared package lsu_pkg shall hold:
  - The FSM state enum.
  - Width constants ADDR_W=16 and DATA_W=16.
REQ-037 One sub-module, lsu_load_fmt (combinational byte select and extension), is natural.
  - The remaining logic stays in load_store_unit.

Verification
REQ-038 Halfword store then load: store 0xBEEF at 0x0010, then load halfword 0x0010.
  - Required: rsp_rdata=0xBEEF, 2 cycles after each acceptance.
REQ-039 Byte store: mem[0x0011:0x0010]=0xBEEF, then store byte 0x5A at 0x0010.
  - Required: exactly one mem_we pulse, with mem_wdata=0xBE5A, in RMW_WR.
  - Required: a subsequent halfword load returns 0xBE5A.
REQ-040 Byte load extension: mem[0x0020]=0x80.
  - Signed byte load returns 0xFF80.
  - Unsigned byte load returns 0x0080.
REQ-041 Wrap: store halfword 0x1234 at 0xFFFF.
  - Required: mem[0xFFFF]=0x34 and mem[0x0000]=0x12.
  - Required: a halfword load at 0xFFFF returns 0x1234.
REQ-042 Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid on a load.
  - Required: rsp_valid and rsp_rdata stable throughout.
  - Required: req_ready=0 throughout.
  - Required: IDLE entered one cycle after rsp_ready=1.
REQ-043 Reset in RMW_WR: assert rst_n=0 at the cycle RMW_WR is entered.
  - Required: no mem_we pulse.
  - Required: rsp_valid=0.
  - Required: req_ready=1 one cycle after rst_n is released.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and width constants for the load/store unit.
package lsu_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RMW_WR = 2'd2,
        S_RESP   = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_load_fmt.sv
// Load result formatting: halfword pass-through, or low byte zero/sign-extended.
module lsu_load_fmt
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] i_rdata,
    input  logic              i_is_byte,
    input  logic              i_is_signed,
    output logic [DATA_W-1:0] o_data
);

    logic w_ext;

    always_comb begin
        w_ext  = i_is_signed & i_rdata[7];
        o_data = i_rdata;
        if (i_is_byte) begin
            o_data = {{8{w_ext}}, i_rdata[7:0]};
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit for a byte-addressed 16-bit memory;
// byte stores are done as read-modify-write to keep the neighbouring byte.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    // state    | meaning
    // S_IDLE   | waiting for a request, req_ready high
    // S_ACCESS | memory read (load / byte store) or halfword write
    // S_RMW_WR | byte store write-back with preserved high byte
    // S_RESP   | response held until rsp_ready

    lsu_state_e        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic              r_byte;
    logic              r_signed;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [DATA_W-1:0] w_load_data;

    lsu_load_fmt u_load_fmt (
        .i_rdata     (mem_rdata),
        .i_is_byte   (r_byte),
        .i_is_signed (r_signed),
        .o_data      (w_load_data)
    );

    // Outputs are registered, so each write pulse is scheduled one edge ahead.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_byte      <= 1'b0;
            r_signed    <= 1'b0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr      <= req_addr;
                        r_we        <= req_we;
                        r_byte      <= req_byte;
                        r_signed    <= req_signed;
                        r_mem_wdata <= req_wdata;
                        r_mem_we    <= req_we & ~req_byte;
                        r_state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!r_we) begin
                        r_rsp_rdata <= w_load_data;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_byte) begin
                        r_mem_wdata <= {mem_rdata[15:8], r_mem_wdata[7:0]};
                        r_mem_we    <= 1'b1;
                        r_state     <= S_RMW_WR;
                    end else begin
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RMW_WR: begin
                    r_rsp_rdata <= '0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;

endmodule
